// File: rtl/multi_rate_divider.sv
// Multi-channel phase-accurate tick generator: each channel accumulates STEP per enabled
// cycle against a run-time period, emitting a one-cycle tick and a toggling square wave on wrap.
module multi_rate_divider #(
   parameter int WIDTH     = 32,
   parameter int CHANNELS  = 4,
   parameter int CHAN_BITS = 2,
   parameter int STEP      = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cfg_we,
   input  logic [CHAN_BITS-1:0] cfg_chan,
   input  logic [WIDTH-1:0]     cfg_period,
   input  logic                 sync,
   input  logic [CHANNELS-1:0]  enable,
   output logic [CHANNELS-1:0]  tick,
   output logic [CHANNELS-1:0]  wave,
   output logic                 tick_any
);

   // One extra bit so count+STEP never wraps before the compare.
   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

   logic [CHANNELS-1:0] tick_next;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic [WIDTH-1:0] period_q;
      logic [WIDTH-1:0] period_d;
      logic [WIDTH-1:0] count_q;
      logic [WIDTH-1:0] count_d;
      logic             wave_q;
      logic             wave_d;
      logic             tick_q;
      logic             tick_d;
      logic [WIDTH:0]   sum;
      logic [WIDTH:0]   period_x;
      logic             wr_hit;
      logic             running;

      assign wr_hit   = cfg_we && (cfg_chan == CHAN_BITS'(c));
      assign sum      = {1'b0, count_q} + STEP_X;
      assign period_x = {1'b0, period_q};
      assign running  = enable[c] && (period_q != '0);

      always_comb begin
         period_d = period_q;
         count_d  = count_q;
         wave_d   = wave_q;
         tick_d   = 1'b0;
         if (wr_hit) begin
            period_d = cfg_period;
            count_d  = '0;
            wave_d   = 1'b0;
         end else if (sync) begin
            count_d = '0;
         end else if (running) begin
            if (period_x <= STEP_X) begin
               count_d = '0;
               tick_d  = 1'b1;
               wave_d  = ~wave_q;
            end else if (sum >= period_x) begin
               // Keep the wrap remainder so the long-run rate has no drift.
               count_d = WIDTH'(sum - period_x);
               tick_d  = 1'b1;
               wave_d  = ~wave_q;
            end else begin
               count_d = sum[WIDTH-1:0];
            end
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            period_q <= '0;
            count_q  <= '0;
            wave_q   <= 1'b0;
            tick_q   <= 1'b0;
         end else begin
            period_q <= period_d;
            count_q  <= count_d;
            wave_q   <= wave_d;
            tick_q   <= tick_d;
         end
      end

      assign tick[c]      = tick_q;
      assign wave[c]      = wave_q;
      assign tick_next[c] = tick_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tick_any <= 1'b0;
      end else begin
         tick_any <= |tick_next;
      end
   end

endmodule
